// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide over magnitudes, with sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] rdata1_i,
  input  logic [WIDTH-1:0] rdata2_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  logic [1:0]         state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  // Upper half: partial product / remainder; lower half: multiplier / dividend-quotient.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   quot, rem;

  assign signed_op = ~funct_i[0];
  assign a_neg     = signed_op & rdata1_i[WIDTH-1];
  assign b_neg     = signed_op & rdata2_i[WIDTH-1];
  // |MIN| negates to itself, which reads correctly as an unsigned magnitude.
  assign a_mag     = a_neg ? -rdata1_i : rdata1_i;
  assign b_mag     = b_neg ? -rdata2_i : rdata2_i;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
  assign quot      = acc_q[WIDTH-1:0];
  assign rem       = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_i && !flush_i) begin
          case (funct_i)
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              state_d   = CALC;
              cnt_d     = '0;
              is_div_d  = funct_i[1];
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              opnd_d    = funct_i[1] ? b_mag : a_mag;
              acc_d     = {{WIDTH{1'b0}}, (funct_i[1] ? a_mag : b_mag)};
            end
            F_MTHI:  hi_d = rdata1_i;
            F_MTLO:  lo_d = rdata1_i;
            default: ;
          endcase
        end
      end
      CALC: begin
        if (is_div_q) begin
          acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
        end else if (acc_q[0]) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
        if (cnt_q == CNTW'(WIDTH - 1)) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      FIX: begin
        if (is_div_q) begin
          // A zero divisor leaves the dividend in the remainder half; only the quotient needs forcing.
          lo_d = (opnd_q == '0) ? '1 : (neg_res_q ? -quot : quot);
          hi_d = neg_rem_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
